// File: rtl/spi_sim_master.sv
// -----------------------------------------------------------------------------
// spi_sim_master
// Single-transaction SPI master (mode 0: CPOL=0, CPHA=0). On an accepted start
// it shifts one frame of CMD_WIDTH command bits followed by DATA_WIDTH data
// bits, MSB first. Command MSB selects direction (1 = read, 0 = write); the
// rest of the command is the register address. Writes drive the data bits on
// MOSI; reads drive 0 during the data phase and sample MISO instead.
// SPI timing is given in ns and converted to clk cycles (ceil, minimum 1).
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   start      request; accepted only while busy = 0 (no queueing)
//   cmd        {dir, addr}, latched at accept
//   wdata      write data, latched at accept
//   busy       high from the accepted start through the end of the CS-high gap
//   done       one-cycle pulse in the cycle CS_n returns high
//   rdata      result of the last completed read frame
//   spi_cs_n   chip select (active low)
//   spi_sclk   serial clock, idles low
//   spi_mosi   master out
//   spi_miso   master in
//   dbg_state  current FSM state, for observation only
//
// Handshake: a transaction is a single-cycle start sampled at a rising clk edge
// while busy = 0; busy rises on the following cycle and the request fields
// are not looked at again until busy has fallen.
// -----------------------------------------------------------------------------
module spi_sim_master #(
   parameter int HIGH       = 1,
   parameter int LOW        = 0,
   parameter int WRITE      = 0,
   parameter int READ       = 1,
   parameter int CMD_WIDTH  = 5,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 11,
   parameter int BYTE       = 8,
   parameter int WORD       = 16,
   parameter int DWORD      = 32,
   parameter int CLK_PERIOD = 10,
   parameter int tCLKL      = 40,
   parameter int tCLKH      = 40,
   parameter int tSU_SDI    = 20,
   parameter int tHD_SDI    = 30,
   parameter int tHD_SDO    = 40,
   parameter int tSU_SCS    = 50,
   parameter int tHD_SCS    = 50,
   parameter int tHI_SCS    = 400
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CMD_WIDTH-1:0]  cmd,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  spi_cs_n,
   output logic                  spi_sclk,
   output logic                  spi_mosi,
   input  logic                  spi_miso,
   output logic [2:0]            dbg_state
);

   function automatic int to_cycles(input int t_ns);
      int n;
      n = (t_ns + CLK_PERIOD - 1) / CLK_PERIOD;
      return (n < 1) ? 1 : n;
   endfunction

   localparam int N_CLKL   = to_cycles(tCLKL);
   localparam int N_CLKH   = to_cycles(tCLKH);
   localparam int N_SU_SCS = to_cycles(tSU_SCS);
   localparam int N_HD_SCS = to_cycles(tHD_SCS);
   localparam int N_HI_SCS = to_cycles(tHI_SCS);

   localparam int F      = CMD_WIDTH + DATA_WIDTH;
   localparam int N_MAX1 = (N_CLKL > N_CLKH) ? N_CLKL : N_CLKH;
   localparam int N_MAX2 = (N_SU_SCS > N_HD_SCS) ? N_SU_SCS : N_HD_SCS;
   localparam int N_MAX3 = (N_MAX1 > N_MAX2) ? N_MAX1 : N_MAX2;
   localparam int N_MAX  = (N_MAX3 > N_HI_SCS) ? N_MAX3 : N_HI_SCS;
   localparam int CNT_W  = $clog2(N_MAX + 1);
   localparam int IDX_W  = $clog2(F);

   // An inconsistent configuration (MOSI setup/hold not met inside the SCLK
   // phases, or malformed field/width constants) never starts a frame.
   localparam bit CFG_OK = (tCLKL >= tSU_SDI) && (tCLKH >= tHD_SDI) &&
                           (tHD_SDO >= 0) && (READ != WRITE) &&
                           (ADDR_WIDTH == CMD_WIDTH - 1) &&
                           (BYTE <= WORD) && (WORD <= DWORD);

   localparam logic SIG_HI = 1'(HIGH);
   localparam logic SIG_LO = 1'(LOW);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CS_SETUP  = 3'd1,
      SCLK_LOW  = 3'd2,
      SCLK_HIGH = 3'd3,
      CS_HOLD   = 3'd4,
      GAP       = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [F-1:0]          frame_q, frame_d;
   logic [DATA_WIDTH-1:0] rsh_q, rsh_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  cs_n_q, cs_n_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;

   logic                  is_read;
   logic [IDX_W-1:0]      nidx;
   logic                  nbit;

   assign is_read = (frame_q[F-1] == 1'(READ));

   // MOSI value for the bit about to start its low phase: bit 0 when leaving
   // CS_SETUP, otherwise the next index. The data phase of a read drives 0.
   always_comb begin
      nidx = (state_q == CS_SETUP) ? '0 : idx_q + IDX_W'(1);
      nbit = frame_q[IDX_W'(F - 1) - nidx];
      if (is_read && (nidx >= IDX_W'(CMD_WIDTH))) begin
         nbit = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      rsh_d   = rsh_q;
      rdata_d = rdata_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      case (state_q)
         IDLE: begin
            if (start && CFG_OK) begin
               frame_d = {cmd, wdata};
               busy_d  = 1'b1;
               cs_n_d  = SIG_LO;
               cnt_d   = '0;
               state_d = CS_SETUP;
            end
         end
         CS_SETUP: begin
            if (cnt_q == CNT_W'(N_SU_SCS - 1)) begin
               cnt_d   = '0;
               idx_d   = '0;
               mosi_d  = nbit;
               state_d = SCLK_LOW;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SCLK_LOW: begin
            if (cnt_q == CNT_W'(N_CLKL - 1)) begin
               cnt_d   = '0;
               sclk_d  = SIG_HI;
               state_d = SCLK_HIGH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SCLK_HIGH: begin
            // The slave updates MISO on the falling edge, so it is stable
            // throughout the high phase; sample once on entry.
            if ((cnt_q == '0) && is_read && (idx_q >= IDX_W'(CMD_WIDTH))) begin
               rsh_d = {rsh_q[DATA_WIDTH-2:0], spi_miso};
            end
            if (cnt_q == CNT_W'(N_CLKH - 1)) begin
               cnt_d  = '0;
               sclk_d = SIG_LO;
               if (idx_q == IDX_W'(F - 1)) begin
                  state_d = CS_HOLD;
               end else begin
                  idx_d   = nidx;
                  mosi_d  = nbit;
                  state_d = SCLK_LOW;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CS_HOLD: begin
            if (cnt_q == CNT_W'(N_HD_SCS - 1)) begin
               cnt_d   = '0;
               cs_n_d  = SIG_HI;
               mosi_d  = 1'b0;
               done_d  = 1'b1;
               if (is_read) begin
                  rdata_d = rsh_q;
               end
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_q == CNT_W'(N_HI_SCS - 1)) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            cs_n_d  = SIG_HI;
            sclk_d  = SIG_LO;
            mosi_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         frame_q <= '0;
         rsh_q   <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         rsh_q   <= rsh_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign spi_cs_n  = cs_n_q;
   assign spi_sclk  = sclk_q;
   assign spi_mosi  = mosi_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_sim_master.sv
// -----------------------------------------------------------------------------
// tb_spi_sim_master
// Drives directed and random SPI register transactions into spi_sim_master.
// A register-file slave answers on MISO and captures writes from MOSI. The
// reference model tracks register contents and the last read result from the
// requested transactions alone, and states the expected frame bits and the
// SPI phase timing in cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_sim_master;

   localparam int CW       = 5;
   localparam int DW       = 11;
   localparam int F        = CW + DW;
   localparam int N_CLKL   = 4;
   localparam int N_CLKH   = 4;
   localparam int N_SU_SCS = 5;
   localparam int N_HD_SCS = 5;
   localparam int N_HI_SCS = 40;
   localparam int BUDGET   = 3000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] cmd = '0;
   logic [DW-1:0] wdata = '0;
   logic          busy, done, spi_cs_n, spi_sclk, spi_mosi;
   logic          spi_miso = 1'b0;
   logic [DW-1:0] rdata;
   logic [2:0]    dbg_state;

   spi_sim_master dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cmd       (cmd),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .spi_cs_n  (spi_cs_n),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [F-1:0]  exp_q[$];
   logic [DW-1:0] mdl_regs[16];
   logic [DW-1:0] mdl_rdata = '0;
   int            last_cs_rise = -1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- register-file slave ----------------
   logic [DW-1:0] slv_regs[16];
   logic [F-1:0]  s_sh = '0;
   int            s_cnt = 0;
   logic          s_prev = 1'b0;
   logic          s_dir = 1'b0;
   logic [3:0]    s_addr = '0;

   always @(negedge clk) begin
      logic [DW-1:0] tmp;
      if (spi_cs_n) begin
         s_cnt = 0;
         spi_miso <= 1'b0;
      end else begin
         if (spi_sclk && !s_prev) begin
            s_sh = {s_sh[F-2:0], spi_mosi};
            s_cnt++;
            if (s_cnt == CW) begin
               s_dir  = s_sh[CW-1];
               s_addr = s_sh[3:0];
            end
            if (s_cnt == F && !s_dir) slv_regs[s_addr] = s_sh[DW-1:0];
         end
         if (!spi_sclk && s_prev && s_cnt >= CW && s_cnt < F && s_dir) begin
            tmp = slv_regs[s_addr];
            spi_miso <= tmp[F - 1 - s_cnt];
         end
      end
      s_prev = spi_sclk;
   end

   // ---------------- driver + frame checker ----------------
   task automatic run_frame(input logic [CW-1:0] c, input logic [DW-1:0] wd, input bit poke);
      int rises = 0, first_rise = 0, last_fall = 0, cs_fall, cs_rise = -1;
      int done_cnt = 0, done_cyc = -1, budget = 0;
      int hi_start = 0, lo_start = 0;
      int min_hi = 1000, max_hi = 0, min_lo = 1000, max_lo = 0;
      logic [F-1:0]  got_mosi = '0;
      logic [F-1:0]  exp_frame;
      logic          prev_sclk = 1'b0;
      logic [DW-1:0] exp_rd;

      // Reference model: a read returns the register, a write updates it.
      exp_q.push_back({c, (c[CW-1] ? {DW{1'b0}} : wd)});
      if (c[CW-1]) begin
         exp_rd = mdl_regs[c[3:0]];
      end else begin
         exp_rd = mdl_rdata;
         mdl_regs[c[3:0]] = wd;
      end
      mdl_rdata = exp_rd;

      @(negedge clk);
      start = 1'b1; cmd = c; wdata = wd;
      @(negedge clk);
      start = 1'b0;
      check_eq("busy_on_accept", busy, 1);
      check_eq("cs_low_on_accept", spi_cs_n, 0);
      cs_fall = cyc;
      if (last_cs_rise >= 0) check_eq("cs_high_gap_ok", (cs_fall - last_cs_rise) >= N_HI_SCS, 1);

      while (busy && budget < BUDGET) begin
         @(negedge clk);
         budget++;
         if (poke && rises == 3) begin
            start = 1'b1; cmd = ~c; wdata = ~wd;
         end else begin
            start = 1'b0;
         end
         if (spi_sclk && !prev_sclk) begin
            rises++;
            got_mosi = {got_mosi[F-2:0], spi_mosi};
            if (rises == 1) begin
               first_rise = cyc;
            end else begin
               if (cyc - lo_start < min_lo) min_lo = cyc - lo_start;
               if (cyc - lo_start > max_lo) max_lo = cyc - lo_start;
            end
            hi_start = cyc;
         end
         if (!spi_sclk && prev_sclk) begin
            last_fall = cyc;
            if (cyc - hi_start < min_hi) min_hi = cyc - hi_start;
            if (cyc - hi_start > max_hi) max_hi = cyc - hi_start;
            lo_start = cyc;
         end
         if (spi_cs_n && cs_rise < 0) cs_rise = cyc;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_sclk = spi_sclk;
      end
      start = 1'b0;
      check_eq("frame_finished_in_budget", busy, 0);

      exp_frame = exp_q.pop_front();
      check_eq("sclk_rises", rises, F);
      check_eq("mosi_frame", got_mosi, exp_frame);
      check_eq("cs_setup_cycles", first_rise - cs_fall, N_SU_SCS + N_CLKL);
      check_eq("sclk_low_min", min_lo, N_CLKL);
      check_eq("sclk_low_max", max_lo, N_CLKL);
      check_eq("sclk_high_min", min_hi, N_CLKH);
      check_eq("sclk_high_max", max_hi, N_CLKH);
      check_eq("cs_hold_cycles", cs_rise - last_fall, N_HD_SCS);
      check_eq("done_pulses", done_cnt, 1);
      check_eq("done_with_cs_rise", done_cyc, cs_rise);
      check_eq("busy_gap_cycles", cyc - cs_rise, N_HI_SCS);
      check_eq("rdata", rdata, exp_rd);
      last_cs_rise = cs_rise;

      if (poke) begin
         repeat (3) @(negedge clk);
         check_eq("ignored_start_no_frame_cs", spi_cs_n, 1);
         check_eq("ignored_start_no_frame_busy", busy, 0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_cs_n"}, spi_cs_n, 1);
      check_eq({tag, "_sclk"}, spi_sclk, 0);
      check_eq({tag, "_mosi"}, spi_mosi, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_rdata"}, rdata, 0);
   endtask

   // Start a write, then reset during the low phase of the 8th bit.
   task automatic reset_mid_frame();
      int rises = 0, budget = 0;
      logic prev_sclk = 1'b0;
      @(negedge clk);
      start = 1'b1; cmd = 5'b01010; wdata = 11'h3C3;
      @(negedge clk);
      start = 1'b0;
      while (!(rises == 7 && !spi_sclk) && budget < BUDGET) begin
         @(negedge clk);
         budget++;
         if (spi_sclk && !prev_sclk) rises++;
         prev_sclk = spi_sclk;
      end
      check_eq("reached_8th_bit", rises, 7);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_frame_reset");
      rst = 1'b0;
      mdl_rdata = '0;
      last_cs_rise = -1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [DW-1:0] r;
      for (int i = 0; i < 16; i++) begin
         r = DW'($urandom_range(0, 2047));
         slv_regs[i] = r;
         mdl_regs[i] = r;
      end
      slv_regs[3] = 11'h2C7;
      mdl_regs[3] = 11'h2C7;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      run_frame(5'b00000, 11'h000, 1'b0);
      run_frame(5'b10011, 11'h000, 1'b0);
      run_frame(5'b00011, 11'h5A5, 1'b0);
      run_frame(5'b00000, 11'h000, 1'b0);
      run_frame(5'b10000, 11'h000, 1'b0);
      run_frame(5'b00000, 11'h7FF, 1'b0);
      run_frame(5'b10000, 11'h7FF, 1'b0);

      // start held during a frame must be ignored, then back-to-back frames
      run_frame({1'b0, 4'(($urandom_range(0, 15)))}, DW'($urandom_range(0, 2047)), 1'b1);
      run_frame(5'b00101, 11'h155, 1'b0);
      run_frame(5'b10101, 11'h6AA, 1'b0);

      reset_mid_frame();
      run_frame(5'b10011, 11'h000, 1'b0);
      run_frame(5'b11010, 11'h000, 1'b0);

      for (int k = 0; k < 8; k++) begin
         run_frame(CW'($urandom_range(0, 31)), DW'($urandom_range(0, 2047)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_sim_master.md
Name: spi_sim_master

Overview:
- Single-transaction SPI master: on request, shifts one frame (CMD_WIDTH command bits, then DATA_WIDTH data bits) MSB-first.
- Command MSB selects direction (1 = read, 0 = write); the remaining ADDR_WIDTH bits are the register address.
- Write: master drives the data bits on MOSI. Read: master samples the data bits from MISO.
- Used in the system bench and as a register-access engine towards an SPI register-file slave. SPI timing is parameterised in ns and converted to clk cycles.

Parameters:
- HIGH, 1, logic-high constant
- LOW, 0, logic-low constant
- WRITE, 0, command-MSB value for write
- READ, 1, command-MSB value for read
- CMD_WIDTH, 5, command field width (1 dir bit + ADDR_WIDTH)
- ADDR_WIDTH, 4, address field width
- DATA_WIDTH, 11, data field width
- BYTE / WORD / DWORD, 8 / 16 / 32, width constants, no functional use
- CLK_PERIOD, 10, clk period in ns for timing conversion
- tCLKL, 40, SCLK low time ns
- tCLKH, 40, SCLK high time ns
- tSU_SDI, 20, MOSI setup to SCLK rise ns
- tHD_SDI, 30, MOSI hold after SCLK rise ns
- tHD_SDO, 40, slave MISO hold ns (informational)
- tSU_SCS, 50, CS_n fall to first SCLK rise ns
- tHD_SCS, 50, last SCLK fall to CS_n rise ns
- tHI_SCS, 400, minimum CS_n high time between frames ns

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  transaction request, accepted only when busy=0
- cmd  in  CMD_WIDTH  {dir, addr}
- wdata  in  DATA_WIDTH  write data
- busy  out  1  high from accepted start through end of CS-high gap
- done  out  1  one-cycle pulse when CS_n returns high
- rdata  out  DATA_WIDTH  last read result
- spi_cs_n  out  1  chip select, active low
- spi_sclk  out  1  serial clock, idle low
- spi_mosi  out  1  master out
- spi_miso  in  1  master in

Behaviour:
- Cycle counts: N_x = ceil(t_x / CLK_PERIOD), minimum 1. Defaults: N_CLKL=4, N_CLKH=4, N_SU_SCS=5, N_HD_SCS=5, N_HI_SCS=40.
- Required relations: tCLKL >= tSU_SDI and tCLKH >= tHD_SDI. MOSI changes only at the start of a low phase.
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, rdata=0, state IDLE.
- Frame length: F = CMD_WIDTH + DATA_WIDTH = 16 bits. Shift register is loaded with {cmd, wdata} at accept.
- FSM:
  - IDLE: start=1 → latch cmd/wdata, busy=1, cs_n=0, go to CS_SETUP.
  - CS_SETUP: N_SU_SCS cycles, then SCLK_LOW with bit index 0.
  - SCLK_LOW: drive mosi = frame bit F-1-index; hold N_CLKL cycles; then sclk=1, go to SCLK_HIGH.
  - SCLK_HIGH: on entry cycle, if read and index >= CMD_WIDTH, sample spi_miso into rdata shift (MSB first). Hold N_CLKH cycles, then sclk=0. If index = F-1 go to CS_HOLD, else index+1 and go to SCLK_LOW.
  - CS_HOLD: N_HD_SCS cycles, then cs_n=1, mosi=0, done=1 for one cycle, go to GAP.
  - GAP: N_HI_SCS cycles with busy=1, then IDLE with busy=0.
- Read data phase: mosi=0. rdata updates only at the end of a read frame. A write frame leaves rdata unchanged.
- start while busy=1 is ignored; there is no queueing.
- rst mid-frame: next cycle all outputs return to reset values and the frame is abandoned. The tHI_SCS gap is not enforced after reset.
- SPI mode 0: CPOL=0, CPHA=0. Exactly F rising SCLK edges per frame.

Test Plan:
- Write cmd=5'b00000, wdata=11'h000 → 16 rising edges with MOSI all 0; CS_n low; done pulse; rdata stays 0.
- Write cmd=5'b00011, wdata=11'h5A5 → MOSI sequence at rises is 00011 then 10110100101; SCLK low/high 4/4 cycles; CS setup 5 cycles and hold 5 cycles.
- Read cmd=5'b10011 with slave model driving 11'h2C7 → MOSI shows 10011 then 0s; rdata=11'h2C7 at done.
- Loopback with register-file slave: write 11'h000 to addr 0, then read addr 0 → rdata=11'h000. Repeat with 11'h7FF → rdata=11'h7FF.
- Back-to-back starts → second start ignored while busy; next CS_n fall occurs at least 40 cycles after the previous CS_n rise.
- rst asserted during the 8th bit → CS_n=1, SCLK=0, busy=0 next cycle; a subsequent read completes correctly.
